// File: rtl/ffsr_pulse_driver.sv
// Command-side driver for a thermometer-coded pulse shift register: absolute load or inc/dec pulse trains.
// Optional build macro FFSR_DRV_CHECK_EN enables the ffsr_out readback checker (sticky mismatch flag).
module ffsr_pulse_driver #(
  parameter int INPUT_SIZE = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load,
  input  logic [CNT_W-1:0]      cmd_target,
  output logic                  ffsr_rst,
  output logic                  ffsr_inc,
  output logic                  ffsr_dec,
  output logic [INPUT_SIZE-1:0] ffsr_init,
  output logic [CNT_W-1:0]      level,
  output logic                  busy,
  output logic                  done,
  input  logic [INPUT_SIZE-1:0] ffsr_out,
  output logic                  mismatch
);

  // state | meaning
  // IDLE  | waiting for a command; also hosts the done cycle
  // LOAD  | ffsr_rst+ffsr_init presented for one cycle
  // STEP  | one inc or dec pulse per cycle until level reaches tgt
  typedef enum logic [1:0] {IDLE, LOAD, STEP} state_t;

  localparam logic [CNT_W-1:0] MAX_LVL = CNT_W'(INPUT_SIZE);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        tgt, tgt_nxt, tgt_clamp, level_nxt;
  logic                    rst_nxt, inc_nxt, dec_nxt, busy_nxt, done_nxt;
  logic [INPUT_SIZE-1:0]   init_nxt;

  function automatic logic [INPUT_SIZE-1:0] therm(input logic [CNT_W-1:0] n);
    logic [INPUT_SIZE-1:0] t;
    t = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign tgt_clamp = (cmd_target > MAX_LVL) ? MAX_LVL : cmd_target;

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    level_nxt = level;
    rst_nxt   = 1'b0;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          tgt_nxt = tgt_clamp;
          if (cmd_load) begin
            state_nxt = LOAD;
            rst_nxt   = 1'b1;
            level_nxt = tgt_clamp;
            busy_nxt  = 1'b1;
          end else if (tgt_clamp > level) begin
            state_nxt = STEP;
            inc_nxt   = 1'b1;
            level_nxt = level + 1'b1;
            busy_nxt  = 1'b1;
          end else if (tgt_clamp < level) begin
            state_nxt = STEP;
            dec_nxt   = 1'b1;
            level_nxt = level - 1'b1;
            busy_nxt  = 1'b1;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      STEP: begin
        // level already reflects the pulse being presented, so equality means the train is complete
        if (level == tgt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (tgt > level) begin
          inc_nxt   = 1'b1;
          level_nxt = level + 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          dec_nxt   = 1'b1;
          level_nxt = level - 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    init_nxt = therm(level_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      level     <= '0;
      ffsr_rst  <= 1'b1;
      ffsr_init <= '0;
      ffsr_inc  <= 1'b0;
      ffsr_dec  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      level     <= level_nxt;
      ffsr_rst  <= rst_nxt;
      ffsr_init <= init_nxt;
      ffsr_inc  <= inc_nxt;
      ffsr_dec  <= dec_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

`ifdef FFSR_DRV_CHECK_EN
  logic mismatch_q;

  // Only compare when the register has settled: idle, not loading, not in the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (state == IDLE && !ffsr_rst && !done && ffsr_out != therm(level)) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic ffsr_out_unused;

  assign ffsr_out_unused = ^ffsr_out;
  assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_ffsr_pulse_driver.sv
// Self-checking bench for ffsr_pulse_driver: per-command expected cycle traces plus a thermometer register model.
module tb_ffsr_pulse_driver;

  logic       clk, rst, cmd_valid, cmd_ready, cmd_load;
  logic [3:0] cmd_target, level;
  logic       ffsr_rst, ffsr_inc, ffsr_dec, busy, done, mismatch;
  logic [7:0] ffsr_init, ffsr_out, reg_q, inject;

  ffsr_pulse_driver #(.INPUT_SIZE(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_target(cmd_target), .ffsr_rst(ffsr_rst),
    .ffsr_inc(ffsr_inc), .ffsr_dec(ffsr_dec), .ffsr_init(ffsr_init),
    .level(level), .busy(busy), .done(done), .ffsr_out(ffsr_out),
    .mismatch(mismatch)
  );

`ifdef FFSR_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driven thermometer register
  always @(posedge clk) begin
    if (ffsr_rst)      reg_q <= ffsr_init;
    else if (ffsr_inc) reg_q <= {reg_q[6:0], 1'b1};
    else if (ffsr_dec) reg_q <= {1'b0, reg_q[7:1]};
  end
  assign ffsr_out = reg_q ^ inject;

  int n_assert = 0, n_fail = 0;
  int inc_cnt = 0, dec_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tb_therm(input int n);
    return 8'((16'd1 << n) - 16'd1);
  endfunction

  typedef struct packed {
    logic       rst, inc, dec;
    logic [7:0] init;
    logic [3:0] lvl;
    logic       busy, done, ready;
  } exp_t;

  exp_t q[$];
  int   m_level = 0;
  bit   started = 0;
  logic exp_mm = 1'b0;

  function automatic exp_t mk(input bit r, input bit i, input bit d, input int l,
                              input bit b, input bit dn, input bit rd);
    exp_t e;
    e.rst = r; e.inc = i; e.dec = d; e.init = tb_therm(l); e.lvl = 4'(l);
    e.busy = b; e.done = dn; e.ready = rd;
    return e;
  endfunction

  // Expand an accepted command into the exact sequence of output cycles it must produce
  task automatic push_cmd(input bit ld, input int target);
    int t, l;
    bit up;
    t = (target > 8) ? 8 : target;
    l = m_level;
    up = (t > l);
    if (ld) q.push_back(mk(1, 0, 0, t, 1, 0, 0));
    else begin
      while (l != t) begin
        l = up ? l + 1 : l - 1;
        q.push_back(mk(0, up, !up, l, 1, 0, 0));
      end
    end
    q.push_back(mk(0, 0, 0, t, 0, 1, 1));
    m_level = t;
  endtask

  always @(posedge clk) begin
    exp_t cur;
    cur = (q.size() != 0) ? q.pop_front() : mk(0, 0, 0, m_level, 0, 0, 1);
    if (rst) begin
      q.delete();
      m_level = 0;
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      exp_mm = 1'b0;
      started = 1;
    end else begin
      if (CHK && cur.ready && !cur.rst && !cur.done && ffsr_out != tb_therm(int'(cur.lvl)))
        exp_mm = 1'b1;
      if (cmd_valid && cur.ready) push_cmd(cmd_load, int'(cmd_target));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      exp_t e, a;
      e = (q.size() != 0) ? q[0] : mk(0, 0, 0, m_level, 0, 0, 1);
      a = {ffsr_rst, ffsr_inc, ffsr_dec, ffsr_init, level, busy, done, cmd_ready};
      chk("cycle_outputs", 32'(a), 32'(e));
      chk("mismatch_flag", 32'(mismatch), 32'(exp_mm));
      if (ffsr_inc || ffsr_dec) begin
        chk("pulse_exclusive", 32'(ffsr_inc & ffsr_dec | ffsr_rst), 32'd0);
        if (ffsr_inc) chk("inc_below_full", 32'(reg_q == 8'hFF), 32'd0);
        if (ffsr_dec) chk("dec_above_zero", 32'(reg_q == 8'h00), 32'd0);
      end
      if (ffsr_inc) inc_cnt++;
      if (ffsr_dec) dec_cnt++;
    end
  end

  task automatic issue(input bit ld, input int target);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_target = 4'(target);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    int s_inc, s_dec;
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_target = '0; inject = '0;
    repeat (3) @(negedge clk);
    chk("rst_ffsr_rst", 32'(ffsr_rst), 32'd1);
    chk("rst_init", 32'(ffsr_init), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ffsr_rst", 32'(ffsr_rst), 32'd0);
    chk("rel_level", 32'(level), 32'd0);
    chk("rel_ready", 32'(cmd_ready), 32'd1);

    s_inc = inc_cnt;
    issue(0, 5); wait_done("up5_done");
    chk("up5_incs", 32'(inc_cnt - s_inc), 32'd5);
    chk("up5_level", 32'(level), 32'd5);
    chk("up5_reg", 32'(reg_q), 32'h1F);

    s_dec = dec_cnt;
    issue(0, 2); wait_done("dn2_done");
    chk("dn2_decs", 32'(dec_cnt - s_dec), 32'd3);
    chk("dn2_reg", 32'(reg_q), 32'h03);

    s_inc = inc_cnt;
    issue(0, 12); wait_done("clamp_done");
    repeat (3) @(negedge clk);
    chk("clamp_incs", 32'(inc_cnt - s_inc), 32'd6);
    chk("clamp_level", 32'(level), 32'd8);
    chk("clamp_reg", 32'(reg_q), 32'hFF);

    issue(1, 2); wait_done("ld2_done");
    s_inc = inc_cnt; s_dec = dec_cnt;
    issue(1, 7);
    chk("ld7_rst", 32'(ffsr_rst), 32'd1);
    chk("ld7_init", 32'(ffsr_init), 32'h7F);
    @(negedge clk);
    chk("ld7_done", 32'(done), 32'd1);
    chk("ld7_level", 32'(level), 32'd7);
    chk("ld7_reg", 32'(reg_q), 32'h7F);
    chk("ld7_no_pulse", 32'(inc_cnt - s_inc + dec_cnt - s_dec), 32'd0);

    issue(0, 7);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_no_pulse", 32'(inc_cnt - s_inc + dec_cnt - s_dec), 32'd0);

    issue(0, 3); wait_done("dn3_done");
    @(negedge clk);
    inject = 8'h10;
    @(negedge clk);
    inject = 8'h00;
    chk("mm_set", 32'(mismatch), 32'(CHK));
    repeat (2) @(negedge clk);
    chk("mm_held", 32'(mismatch), 32'(CHK));

    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk); @(negedge clk);
    chk("mm_cleared", 32'(mismatch), 32'd0);

    s_inc = inc_cnt;
    issue(0, 6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_inc", 32'(ffsr_inc), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_incs", 32'(inc_cnt - s_inc), 32'd2);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_reg", 32'(reg_q), 32'h00);

    issue(0, 3); wait_done("b2b_first_done");
    issue(0, 1);
    chk("b2b_first_dec", 32'(ffsr_dec), 32'd1);
    chk("b2b_level", 32'(level), 32'd2);
    wait_done("b2b_second_done");
    chk("b2b_reg", 32'(reg_q), 32'h01);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ffsr_pulse_driver.md
Name: ffsr_pulse_driver

Overview:
- Command-side controller for the thermometer-coded pulse shift register (rst/inc/dec/init interface).
- Accepts binary target levels over a valid/ready handshake and drives the register to each target.
- Two ways to reach a target: a single-cycle absolute load (rst + init), or a train of one-per-cycle inc/dec pulses.
- Keeps a binary mirror of the register's level so upstream logic never decodes thermometer code.

Parameters:
- INPUT_SIZE, 8, width of the driven thermometer register; must be >1.
- CNT_W, 4, width of binary level/target fields; must satisfy 2**CNT_W > INPUT_SIZE.

Ports:
- clk  input  1  clock, shared with the driven register.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  driver can accept a command this cycle.
- cmd_load  input  1  1 = absolute load, 0 = step via pulses.
- cmd_target  input  CNT_W  requested level (count of ones).
- ffsr_rst  output  1  to register rst.
- ffsr_inc  output  1  to register inc.
- ffsr_dec  output  1  to register dec.
- ffsr_init  output  INPUT_SIZE  to register init.
- level  output  CNT_W  binary mirror of the register level.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- ffsr_out  input  INPUT_SIZE  register's out bus (used only with the checker).
- mismatch  output  1  sticky check failure.

Behaviour:
- Output timing:
  - All outputs are registered, except cmd_ready = (state==IDLE).
  - The register samples ffsr_* on the edge after they are driven.
- Reset (rst=1 at an edge):
  - state=IDLE, level=0, ffsr_inc=0, ffsr_dec=0, busy=0, done=0, mismatch=0.
  - ffsr_rst=1 and ffsr_init=0, so the register clears on the next edge.
  - ffsr_rst drops to 0 one cycle after rst deasserts.
  - Reset mid-command abandons the command immediately; no further pulses are issued.
- Thermometer encoding: T(n) has bits [n-1:0]=1 and all other bits 0.
- Clamping: at accept, an effective target tgt = min(cmd_target, INPUT_SIZE) is latched.
- Accept: occurs on an edge where cmd_valid && cmd_ready.
- IDLE state:
  - On accept with cmd_load=1: go to LOAD.
  - On accept with cmd_load=0 and tgt!=level: go to STEP.
  - On accept with cmd_load=0 and tgt==level: no pulse; done=1 next cycle; stay IDLE.
- LOAD state:
  - Lasts exactly one cycle: ffsr_rst=1, ffsr_init=T(tgt), level=tgt, busy=1.
  - Next cycle: ffsr_rst=0, done=1, return to IDLE.
- STEP state:
  - Each cycle drives exactly one of ffsr_inc (tgt>level) or ffsr_dec (tgt<level).
  - level is updated ±1 on the same edge the pulse is registered.
  - busy=1 throughout.
  - When the updated level equals tgt, the following cycle has both pulses 0, done=1, and the state returns to IDLE.
- Latency:
  - A step command yields exactly |tgt - level_start| pulse cycles, then a done cycle.
  - A load command takes 1 cycle, then a done cycle.
- Invariants:
  - ffsr_inc and ffsr_dec are never both 1.
  - ffsr_rst is never 1 together with a pulse.
  - No inc while level==INPUT_SIZE; no dec while level==0.
  - ffsr_init is held at T(level) whenever ffsr_rst=0.
- done and cmd_ready:
  - cmd_ready is 1 in the done cycle, so back-to-back commands are accepted there.
  - The next command's first output appears one cycle later.
- Inputs ignored while busy: cmd_* is not sampled while cmd_ready=0.

Optional Feature:
- Macro: FFSR_DRV_CHECK_EN.
- Defined:
  - Every cycle with state==IDLE, ffsr_rst=0 and done=0, ffsr_out is compared against T(level).
  - Any difference sets mismatch=1; it stays set until rst.
- Not defined:
  - ffsr_out is ignored and mismatch is tied to 0.
  - Port list is identical in both builds.

Test Plan:
- Reset behaviour: rst for 3 cycles, then release -> ffsr_rst=1 and init=0 while rst is high, 0 one cycle after release; level=0; cmd_ready=1.
- Step up: step command with target=5 from level 0 -> exactly 5 consecutive ffsr_inc cycles, level goes 1..5, then done=1 with no pulse; register out=8'b00011111.
- Step down then clamp: step to 2 from 5 -> 3 ffsr_dec cycles, out=8'b00000011. Then step to 12 -> clamped to 8, 6 inc cycles, level=8, no inc issued at level 8.
- Load and zero-distance step: load target 7 from level 2 -> one cycle ffsr_rst=1 with init=8'b01111111, no pulses, done next cycle, level=7. Step to 7 at level 7 -> no pulse, done one cycle after accept.
- Reset mid-step and back-to-back: assert rst after the 2nd inc of a 0->6 step -> no further inc, level=0, register cleared. Issue a new step command in the done cycle -> accepted there, its first pulse the next cycle.
- Checker (FFSR_DRV_CHECK_EN): force one bit of ffsr_out while IDLE at level 3 -> mismatch=1 from the next cycle, held after the force is released, cleared only by rst. Without the macro, mismatch stays 0.
